uart_tx: RTL and testbench

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts a parallel byte with a one-cycle valid strobe and serialises it LSB-first onto TX_OUT. The frame is: start bit (0), WIDTH data bits, an optional parity bit, then a stop bit (1). Each bit lasts Prescale CLK cycles, so one Prescale value drives both ends of the link.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
// State encodings and line levels must match on both ends.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic EVEN      = 1'b1;
  localparam logic ODD       = 1'b0;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int PRESCALE_W = 9;

  function automatic logic [PRESCALE_W-1:0] clamp_prescale(
    input logic [PRESCALE_W-1:0] p,
    input logic [PRESCALE_W-1:0] min_p
  );
    return (p < min_p) ? min_p : p;
  endfunction

  function automatic logic parity_of(
    input logic [31:0] data,
    input logic [31:0] mask,
    input logic        typ
  );
    logic x;
    x = ^(data & mask);
    return (typ == ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: holds the clamped period and flags the last
// cycle of every bit so the FSM can advance.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int MIN_PRESCALE = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tc
);

  localparam logic [PRESCALE_W-1:0] MIN_P =
    PRESCALE_W'(MIN_PRESCALE);

  logic [PRESCALE_W-1:0] period_q;
  logic [PRESCALE_W-1:0] cnt_q;

  assign tc = en && (cnt_q == period_q - PRESCALE_W'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= clamp_prescale(prescale, MIN_P);
      cnt_q    <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity,
// stop bit; TX_OUT comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN_PRESCALE = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      P_DATA,
  input  logic                  DATA_VALID,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  uart_state_e state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic [WIDTH-1:0] data_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic             tx_q, tx_d;
  logic             accept;
  logic             tc;
  logic             par_bit;

  assign accept = (state_q == IDLE) && DATA_VALID;
  assign idx_nxt = idx_q + IW'(1);
  assign par_bit = (par_typ_q == ODD) ? ~^data_q : ^data_q;

  assign TX_OUT = tx_q;
  assign BUSY   = (state_q != IDLE);

  uart_bit_timer #(
    .MIN_PRESCALE(MIN_PRESCALE)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (accept),
    .en      (state_q != IDLE),
    .prescale(Prescale),
    .tc      (tc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        tx_d  = STOP_BIT;
        if (DATA_VALID) begin
          state_d = START;
          tx_d    = START_BIT;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (tc) begin
          if (idx_q == LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = STOP_BIT;
            end
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
      STOP: begin
        if (tc) begin
          state_d = IDLE;
          tx_d    = STOP_BIT;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames,
// a line monitor decodes TX_OUT and compares.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic [8:0] Prescale = 9'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       BUSY;

  uart_tx #(
    .WIDTH(W),
    .MIN_PRESCALE(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    logic       par_bit;
    int         p;
    int         cycles;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_busy = 1'b0;
  int   mon_bcnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_bit(input int p, output logic v,
                          output bit stable, output bit ab);
    v = TX_OUT;
    stable = 1'b1;
    ab = !RST;
    if (BUSY === 1'b1) mon_bcnt++;
    for (int i = 1; i < p && !ab; i++) begin
      @(negedge CLK);
      if (!RST) ab = 1'b1;
      else begin
        if (TX_OUT !== v) stable = 1'b0;
        if (BUSY === 1'b1) mon_bcnt++;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic bits [0:11];
    logic v;
    bit st, ab, stable;
    int nb, n;
    logic [7:0] d;
    forever begin
      @(negedge CLK);
      if (RST && TX_OUT === 1'b0) begin
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          check("unexpected_frame", 32'(1), 32'(0));
          n = 0;
          while (BUSY === 1'b1 && RST && n < 20000) begin
            @(negedge CLK);
            n++;
          end
        end else begin
          e = q.pop_front();
          nb = W + 2 + (e.par_en ? 1 : 0);
          ab = 1'b0;
          stable = 1'b1;
          mon_bcnt = 0;
          for (int b = 0; b < nb && !ab; b++) begin
            if (b > 0) @(negedge CLK);
            read_bit(e.p, v, st, ab);
            bits[b] = v;
            if (!st) stable = 1'b0;
          end
          if (!ab) begin
            for (int i = 0; i < W; i++) d[i] = bits[i+1];
            check("start_bit", 32'(bits[0]), 32'(0));
            check("data", 32'(d), 32'(e.data));
            if (e.par_en)
              check("parity_bit", 32'(bits[W+1]), 32'(e.par_bit));
            check("stop_bit", 32'(bits[nb-1]), 32'(1));
            check("bit_stable", 32'(stable), 32'(1));
            @(negedge CLK);
            check("busy_cycles", 32'(mon_bcnt), 32'(e.cycles));
            check("busy_fall", 32'(BUSY), 32'(0));
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_busy_low(input int limit);
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) check("busy_timeout", 32'(1), 32'(0));
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    @(negedge CLK);
    while ((q.size() != 0 || mon_busy || BUSY !== 1'b0) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) check("drain_timeout", 32'(1), 32'(0));
    repeat (2) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic pe,
                      input logic pt, input logic [8:0] ps,
                      input logic exp_par, input int exp_p,
                      input int exp_cyc);
    wait_busy_low(5000);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Prescale = ps;
    DATA_VALID = 1'b1;
    q.push_back('{data: d, par_en: pe, par_bit: exp_par,
                  p: exp_p, cycles: exp_cyc});
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rd;
    logic rt;
    int n;

    repeat (3) @(negedge CLK);
    check("reset_tx", 32'(TX_OUT), 32'(1));
    check("reset_busy", 32'(BUSY), 32'(0));
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_tx", 32'(TX_OUT), 32'(1));

    // A5, no parity, P=8: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 9'd8, 1'b0, 8, 80);
    drain(5000);

    send(8'h07, 1'b1, EVEN, 9'd16, 1'b1, 16, 176);
    drain(5000);
    send(8'h07, 1'b1, ODD, 9'd16, 1'b0, 16, 176);
    drain(5000);

    // DATA_VALID held through the frame, then C3 back-to-back
    wait_busy_low(5000);
    P_DATA = 8'h3C;
    PAR_EN = 1'b0;
    Prescale = 9'd8;
    DATA_VALID = 1'b1;
    q.push_back('{data: 8'h3C, par_en: 1'b0, par_bit: 1'b0,
                  p: 8, cycles: 80});
    @(negedge CLK);
    n = 0;
    while (BUSY === 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_idle_gap", 32'(BUSY), 32'(0));
    P_DATA = 8'hC3;
    q.push_back('{data: 8'hC3, par_en: 1'b0, par_bit: 1'b0,
                  p: 8, cycles: 80});
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check("b2b_start", 32'(TX_OUT), 32'(0));
    check("b2b_busy", 32'(BUSY), 32'(1));
    drain(5000);

    // clamp to 4 and mid-frame input changes
    send(8'hFF, 1'b0, 1'b0, 9'd2, 1'b0, 4, 40);
    repeat (6) @(negedge CLK);
    P_DATA = 8'h00;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    Prescale = 9'd20;
    drain(5000);
    send(8'h81, 1'b0, 1'b0, 9'd0, 1'b0, 4, 40);
    drain(5000);
    send(8'h6E, 1'b1, EVEN, 9'd5, 1'b1, 5, 55);
    drain(5000);

    // reset during data bit 3
    send(8'h5A, 1'b0, 1'b0, 9'd8, 1'b0, 8, 80);
    repeat (35) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("rst_mid_tx", 32'(TX_OUT), 32'(1));
    check("rst_mid_busy", 32'(BUSY), 32'(0));
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("post_rst_tx", 32'(TX_OUT), 32'(1));
    check("post_rst_busy", 32'(BUSY), 32'(0));
    send(8'h5A, 1'b0, 1'b0, 9'd8, 1'b0, 8, 80);
    drain(5000);

    // loopback-style random bytes, P=32 with parity
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom_range(0, 255));
      rt = 1'($urandom_range(0, 1));
      send(rd, 1'b1, rt, 9'd32, rt ? ^rd : ~^rd, 32, 352);
    end
    drain(20000);

    check("queue_empty", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
